flag_register: RTL
==================

// Module: flag_register
// PURPOSE
//  Architectural NZCV flag state for the pipelined LEGv8 CPU, directly downstream of the ALU flag
//  decoder. Latches N/Z/C/V when a flag-setting EX instruction (ADDS/SUBS/ANDS) retires its EX
//  stage. Evaluates B.cond conditions for the branch stage, bypassing same-cycle EX flags or
//  raising a hazard stall. Also registers the branch decision for the next pipeline stage.
// PARAMETERS
//  BYPASS_EN  1  1: forward EX flags to condition evaluation; 0: stall on an EX flag write instead
// PORTS
//  clk            in   1  system clock; all state updates on posedge
//  reset          in   1  synchronous, active-high reset
//  stall          in   1  pipeline freeze; holds all state
//  flush          in   1  squash the current EX instruction (kills its flag write)
//  ex_valid       in   1  EX stage holds a real instruction
//  ex_set_flags   in   1  EX instruction writes flags
//  ex_negative    in   1  N from ALU flag decoder
//  ex_zero        in   1  Z from ALU flag decoder
//  ex_carry_out   in   1  C from ALU flag decoder
//  ex_overflow    in   1  V from ALU flag decoder
//  id_cond_valid  in   1  branch stage holds a B.cond
//  id_cond        in   4  LEGv8 condition code
//  flags_q        out  4  architectural {N,Z,C,V}
//  cond_taken     out  1  combinational: B.cond condition is true this cycle
//  cond_taken_q   out  1  cond_taken registered for the next stage
//  hazard_stall   out  1  combinational: branch must wait one cycle (BYPASS_EN=0 only)
// BEHAVIOUR
//  - Reset: flags_q=4'b0000 and cond_taken_q=0. Reset overrides stall, flush and write.
//  - ex_wr = ex_valid & ex_set_flags & ~flush.
//  - Write: at posedge, if ex_wr & ~stall then flags_q <= {ex_negative,ex_zero,ex_carry_out,ex_overflow}.
//    Otherwise flags_q holds. Stall blocks the write; the write happens on the first unstalled edge.
//  - Effective flags eff: with BYPASS_EN=1 and ex_wr, eff = EX flags; otherwise eff = flags_q.
//  - Condition table (cond -> true when):
//      0000 EQ: Z       0001 NE: ~Z      0010 HS: C        0011 LO: ~C
//      0100 MI: N       0101 PL: ~N      0110 VS: V        0111 VC: ~V
//      1000 HI: C&~Z    1001 LS: ~(C&~Z) 1010 GE: N==V     1011 LT: N!=V
//      1100 GT: ~Z&(N==V)                1101 LE: ~(~Z&(N==V))
//      1110/1111 AL: 1
//  - hazard_stall = (BYPASS_EN==0) & id_cond_valid & ex_wr. It is always 0 when BYPASS_EN=1.
//  - cond_taken = id_cond_valid & ~hazard_stall & eval(eff,id_cond). Zero latency: combinational
//    from the inputs and flags_q.
//  - cond_taken_q update at posedge:
//      reset or flush -> 0
//      stall          -> hold
//      else           -> cond_taken
//  - With hazard_stall, the pipeline control is expected to hold the branch stage. On the following
//    cycle the new flags are in flags_q and evaluation uses them.
//  - Back-to-back flag writes: the last unstalled, unflushed write wins. A B.cond sees the youngest
//    older write through the bypass.
//  - Non-flag-setting instructions, or ex_valid=0, never modify flags_q.
// TESTING
//  1. Reset mid-stream: write NZCV=1111, then assert reset one cycle -> flags_q=0000, cond_taken_q=0.
//  2. Write/hold: ex_wr with N0 Z1 C1 V0 -> flags_q=4'b0110 next cycle; an ADD (no set) leaves 0110.
//  3. Bypass (BYPASS_EN=1): flags_q=0000, EX SUBS gives Z=1, same cycle id_cond=EQ ->
//     cond_taken=1, hazard_stall=0.
//  4. No bypass (BYPASS_EN=0): same stimulus as 3 -> hazard_stall=1, cond_taken=0.
//     Next cycle (ex_wr=0) -> cond_taken=1.
//  5. Flush/stall: ex_wr with Z=1 plus flush -> flags_q unchanged. ex_wr plus stall for 2 cycles ->
//     flags_q updates only on the edge after stall drops; cond_taken_q holds while stalled.
//  6. Exhaustive: all 16 id_cond values x all 16 NZCV states from flags_q -> cond_taken matches the
//     condition table; GE/LT with N=1,V=0 -> GE=0, LT=1.

Source files
------------

// File: rtl/flag_register.sv
// ---------------------------------------------------------------------------
// flag_register
//   Architectural NZCV flag state for the pipelined LEGv8 CPU. The block
//   latches N/Z/C/V when a flag-setting EX instruction (ADDS/SUBS/ANDS)
//   leaves EX. It evaluates B.cond conditions for the branch stage, and it
//   registers the branch decision for the next stage.
//
//   When BYPASS_EN=1, flags that EX writes in the same cycle are forwarded
//   to the condition evaluation. When BYPASS_EN=0, a branch that sees an
//   EX flag write in the same cycle raises hazard_stall. The pipeline control
//   then holds the branch stage for one cycle, and on that next cycle the new
//   flags are in flags_q.
//
// Parameters
//   BYPASS_EN     1: forward EX flags to the condition evaluation
//                 0: stall instead of forwarding
//
// Ports
//   clk            in   1  system clock; all state updates on posedge
//   reset          in   1  synchronous, active-high reset
//   stall          in   1  pipeline freeze; holds all state
//   flush          in   1  squashes the EX instruction (kills its flag write)
//   ex_valid       in   1  EX stage holds a real instruction
//   ex_set_flags   in   1  EX instruction writes flags
//   ex_negative    in   1  N from the ALU flag decoder
//   ex_zero        in   1  Z from the ALU flag decoder
//   ex_carry_out   in   1  C from the ALU flag decoder
//   ex_overflow    in   1  V from the ALU flag decoder
//   id_cond_valid  in   1  branch stage holds a B.cond
//   id_cond        in   4  LEGv8 condition code
//   flags_q        out  4  architectural {N,Z,C,V}
//   cond_taken     out  1  combinational: the B.cond condition is true now
//   cond_taken_q   out  1  cond_taken registered for the next stage
//   hazard_stall   out  1  combinational: the branch must wait one cycle
//
// Control semantics: this block has no valid/ready handshake.
//   - Asserting stall freezes every register.
//   - Asserting flush kills the EX flag write and clears cond_taken_q.
//   - When hazard_stall is raised, the pipeline control is expected to
//     re-present the same B.cond on the next cycle.
// ---------------------------------------------------------------------------
module flag_register #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  logic       ex_valid,
  input  logic       ex_set_flags,
  input  logic       ex_negative,
  input  logic       ex_zero,
  input  logic       ex_carry_out,
  input  logic       ex_overflow,
  input  logic       id_cond_valid,
  input  logic [3:0] id_cond,
  output logic [3:0] flags_q,
  output logic       cond_taken,
  output logic       cond_taken_q,
  output logic       hazard_stall
);

  logic       ex_wr;
  logic [3:0] ex_flags;
  logic [3:0] eff;
  logic       cond_true;
  logic       n, z, c, v;
  logic [3:0] flags_d;
  logic       cond_taken_d;

  // A flushed instruction never reaches architectural state.
  assign ex_wr    = ex_valid & ex_set_flags & ~flush;
  assign ex_flags = {ex_negative, ex_zero, ex_carry_out, ex_overflow};

  // Bypass forwards the flags of the youngest older write, which is the
  // instruction currently in EX.
  assign eff = (BYPASS_EN && ex_wr) ? ex_flags : flags_q;
  assign n   = eff[3];
  assign z   = eff[2];
  assign c   = eff[1];
  assign v   = eff[0];

  always_comb begin
    cond_true = 1'b0;
    unique case (id_cond)
      4'b0000: cond_true = z;                    // EQ
      4'b0001: cond_true = ~z;                   // NE
      4'b0010: cond_true = c;                    // HS
      4'b0011: cond_true = ~c;                   // LO
      4'b0100: cond_true = n;                    // MI
      4'b0101: cond_true = ~n;                   // PL
      4'b0110: cond_true = v;                    // VS
      4'b0111: cond_true = ~v;                   // VC
      4'b1000: cond_true = c & ~z;               // HI
      4'b1001: cond_true = ~(c & ~z);            // LS
      4'b1010: cond_true = (n == v);             // GE
      4'b1011: cond_true = (n != v);             // LT
      4'b1100: cond_true = ~z & (n == v);        // GT
      4'b1101: cond_true = ~(~z & (n == v));     // LE
      default: cond_true = 1'b1;                 // AL (1110, 1111)
    endcase
  end

  assign hazard_stall = !BYPASS_EN && id_cond_valid && ex_wr;
  assign cond_taken   = id_cond_valid & ~hazard_stall & cond_true;

  always_comb begin
    flags_d      = flags_q;
    cond_taken_d = cond_taken_q;
    if (!stall && ex_wr) begin
      flags_d = ex_flags;
    end
    // A flush clears the decision even during a stall. A flush normally
    // also kills the flag write, so only the flag update honours stall.
    if (flush) begin
      cond_taken_d = 1'b0;
    end else if (!stall) begin
      cond_taken_d = cond_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q      <= 4'b0000;
      cond_taken_q <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      cond_taken_q <= cond_taken_d;
    end
  end

endmodule
